// File: rtl/cache.sv
// cache: read-only direct-mapped cache with single-cycle refill from a fixed-content backing memory
module cache #(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_WORDS      = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  output logic [31:0] Data_Out,
  output logic        Hit_Miss
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int MEM_W = $clog2(MEM_WORDS);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];
  logic [IDX_W-1:0]     idx;
  logic [OFF_W-1:0]     off;
  logic [TAG_W-1:0]     atag;
  logic [MEM_W-1:0]     waddr;
  logic                 hit;
  function automatic logic [31:0] rom(input logic [MEM_W-1:0] a);
    return 32'hC0DE_0000 + 32'(a);
  endfunction
  always_comb begin
    off   = Address[OFF_W+1:2];
    idx   = Address[IDX_W+OFF_W+1:OFF_W+2];
    atag  = Address[31:IDX_W+OFF_W+2];
    waddr = Address[MEM_W+1:2];
    hit   = valid_q[idx] && tag_q[idx] == atag;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      Data_Out <= '0;
      Hit_Miss <= 1'b0;
    end else if (hit) begin
      Hit_Miss <= 1'b1;
      Data_Out <= data_q[idx][off];
    end else begin
      valid_q[idx] <= 1'b1;
      tag_q[idx]   <= atag;
      for (int i = 0; i < WORDS_PER_LINE; i++)
        data_q[idx][i] <= rom({waddr[MEM_W-1:OFF_W], OFF_W'(i)});
      Hit_Miss <= 1'b0;
      Data_Out <= rom(waddr);
    end
  end
endmodule

// File: tb/tb_cache.sv
// tb_cache: vector table plus randomized scoreboard check of the direct-mapped cache
module tb_cache;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Address;
  logic [31:0] Data_Out;
  logic        Hit_Miss;
  int          n_run  = 0;
  int          n_fail = 0;

  typedef struct {
    logic        r;
    logic [31:0] a;
    logic        h;
    logic [31:0] d;
  } vec_t;

  typedef struct {
    logic        h;
    logic [31:0] d;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[17];
  logic [23:0] mt[16];
  logic [15:0] mv;

  cache dut (.clk(clk), .rst(rst), .Address(Address), .Data_Out(Data_Out), .Hit_Miss(Hit_Miss));

  always #5 clk = ~clk;

  task automatic step(input string nm, input logic r, input logic [31:0] a, input logic h, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    rst = r;
    Address = a;
    sb.push_back('{h, d});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_run++;
    if (Hit_Miss !== e.h || Data_Out !== e.d) begin
      n_fail++;
      $display("FAIL %s addr=%h: got hit=%b data=%h, want hit=%b data=%h", nm, a, Hit_Miss, Data_Out, e.h, e.d);
    end
  endtask

  initial begin
    rst = 1'b1;
    Address = '0;
    tbl[0]  = '{1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 32'h0000_0008, 1'b0, 32'hC0DE_0002};
    tbl[2]  = '{1'b0, 32'h0000_0008, 1'b1, 32'hC0DE_0002};
    tbl[3]  = '{1'b0, 32'h0000_0008, 1'b1, 32'hC0DE_0002};
    tbl[4]  = '{1'b0, 32'h0000_000C, 1'b1, 32'hC0DE_0003};
    tbl[5]  = '{1'b0, 32'h0000_0000, 1'b1, 32'hC0DE_0000};
    tbl[6]  = '{1'b0, 32'h0000_000B, 1'b1, 32'hC0DE_0002};
    tbl[7]  = '{1'b0, 32'h0000_0108, 1'b0, 32'hC0DE_0042};
    tbl[8]  = '{1'b0, 32'h0000_0008, 1'b0, 32'hC0DE_0002};
    tbl[9]  = '{1'b0, 32'h0000_0108, 1'b0, 32'hC0DE_0042};
    tbl[10] = '{1'b1, 32'h0000_0008, 1'b0, 32'h0000_0000};
    tbl[11] = '{1'b0, 32'h0000_0008, 1'b0, 32'hC0DE_0002};
    tbl[12] = '{1'b0, 32'h0000_0008, 1'b1, 32'hC0DE_0002};
    tbl[13] = '{1'b0, 32'h1000_0008, 1'b0, 32'hC0DE_0002};
    tbl[14] = '{1'b0, 32'h0000_0008, 1'b0, 32'hC0DE_0002};
    tbl[15] = '{1'b0, 32'h0000_0FFC, 1'b0, 32'hC0DE_03FF};
    tbl[16] = '{1'b0, 32'h0000_0FF0, 1'b1, 32'hC0DE_03FC};
    for (int i = 0; i < 17; i++)
      step($sformatf("vec%0d", i), tbl[i].r, tbl[i].a, tbl[i].h, tbl[i].d);
    // whole-line refill: touch word 1 of line 5, then every word must hit
    step("line_fill", 1'b0, 32'h0000_0354, 1'b0, 32'hC0DE_00D5);
    for (int w = 0; w < 4; w++)
      step($sformatf("line_word%0d", w), 1'b0, 32'h0000_0350 + 32'(w * 4), 1'b1, 32'hC0DE_00D4 + 32'(w));
    step("rand_reset", 1'b1, 32'h0, 1'b0, 32'h0);
    mv = '0;
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      logic        h;
      a = {($urandom_range(0, 7) == 0) ? 4'h8 : 4'h0, 18'h0, 10'($urandom_range(0, 1023))};
      h = mv[a[7:4]] && mt[a[7:4]] == a[31:8];
      mv[a[7:4]] = 1'b1;
      mt[a[7:4]] = a[31:8];
      step("rand", 1'b0, a, h, 32'hC0DE_0000 + {22'h0, a[11:2]});
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/cache.md
Name: cache

Overview:
- Read-only, direct-mapped cache with an internal backing memory (ROM model) and single-cycle refill.
- Every rising clock edge performs one lookup of `Address`, then registers the hit/miss flag and the addressed 32-bit word.
- Used as a standalone cache model in front of a fixed-content main memory.

Parameters:
- NUM_LINES, 16, number of cache lines; power of 2; index width IDX_W = log2(NUM_LINES).
- WORDS_PER_LINE, 4, 32-bit words per line; power of 2; word-offset width OFF_W = log2(WORDS_PER_LINE).
- MEM_WORDS, 1024, depth of the internal backing memory in 32-bit words; power of 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Address  input  32  byte address of the word to read.
- Data_Out  output  32  registered read data.
- Hit_Miss  output  1  registered lookup result: 1 = hit, 0 = miss.

Behaviour:
- Address split:
  - Bits [1:0]: byte offset, ignored.
  - Next OFF_W bits: word offset.
  - Next IDX_W bits: line index.
  - Remaining upper bits: tag (24 bits at defaults).
- Per line: valid bit, tag, WORDS_PER_LINE data words.
- Backing memory:
  - Word address = Address[31:2] truncated to log2(MEM_WORDS) bits.
  - Fixed content: word w holds 32'hC0DE_0000 + w.
  - Never written.
- Reset:
  - When rst = 1 at a rising edge, all valid bits clear, Data_Out <= 0, Hit_Miss <= 0.
  - Tag and data arrays need not be cleared.
  - Reset has priority over any lookup in that cycle.
- Lookup (each rising edge with rst = 0):
  - Hit condition: the indexed line's valid bit is set and its stored tag equals the address tag, evaluated on state before the edge.
  - On hit: Hit_Miss <= 1; Data_Out <= line word at the word offset; cache contents unchanged.
  - On miss: the whole line is refilled in the same edge from the aligned memory block (memory word base = word address with low OFF_W bits zeroed, + 0..WORDS_PER_LINE-1). Tag <= address tag, valid <= 1, Hit_Miss <= 0, Data_Out <= memory word at the requested address.
- Latency:
  - Outputs reflect the Address sampled at the most recent rising edge.
  - Data is correct on both hit and miss (one-cycle result either way).
- Repeated lookups: holding Address constant performs a new lookup every cycle. The first lookup misses; all following ones hit.
- Conflicts:
  - Two addresses with the same index and different tags evict each other. Each access after an eviction misses.
  - Addresses aliasing in memory (differing only above memory range) still compare full tags.
- Outputs only change on rising edges; no combinational path from Address to outputs.
- No handshake; a lookup is accepted every cycle.
- Before the first edge after power-up, outputs are undefined until reset is applied.

Test Plan:
- Reset then Address=32'h0000_0008 for one cycle -> Hit_Miss=0, Data_Out=32'hC0DE_0002.
- Hold Address=32'h0000_0008 two more cycles -> Hit_Miss=1 both cycles, Data_Out=32'hC0DE_0002.
- Then Address=32'h0000_000C (same line, word 3) -> Hit_Miss=1, Data_Out=32'hC0DE_0003; Address=32'h0000_0000 -> hit, 32'hC0DE_0000.
- Conflict (defaults): Address=32'h0000_0008 (miss, fills line 0), then 32'h0000_0108 (index 0, tag 1) -> miss, Data_Out=32'hC0DE_0042; then 32'h0000_0008 again -> miss, 32'hC0DE_0002.
- Byte offset ignored: after 32'h0000_0008 is cached, Address=32'h0000_000B -> hit, Data_Out=32'hC0DE_0002.
- Reset mid-operation:
  - After line 0 is valid, assert rst for one cycle -> Data_Out=0, Hit_Miss=0.
  - Then Address=32'h0000_0008 -> miss (valid cleared), Data_Out=32'hC0DE_0002.
  - Next cycle -> hit.
